// File: rtl/secuenciador_estado.sv
// secuenciador_estado: coin-credit counter and step sequencer
// feeding the downstream step decoder; all outputs registered.
module secuenciador_estado #(
  parameter int NUM_ESTADOS = 6,
  parameter int CREDITO_MAX = 15,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       moneda,
  input  logic       boton,
  output logic [2:0] estado,
  output logic       avance,
  output logic       credito,
  output logic [3:0] creditos,
  output logic       fin
);

  localparam int TW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLIM =
    (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [2:0] ULT = 3'(NUM_ESTADOS - 1);
  localparam logic [3:0] CMAX = 4'(CREDITO_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10
  } fsm_t;

  fsm_t          fsm, fsm_n;
  logic [2:0]    msync, bsync;
  logic          mp, bp;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    estado_n;
  logic [3:0]    creditos_n;
  logic          fin_n;
  logic          hecho;
  logic          tmo;

  // two-flop synchronisers plus a third flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      msync <= '0;
      bsync <= '0;
    end else begin
      msync <= {msync[1:0], moneda};
      bsync <= {bsync[1:0], boton};
    end
  end

  assign mp  = msync[1] & ~msync[2];
  assign bp  = bsync[1] & ~bsync[2];
  assign tmo = TO_EN && (tcnt == TLIM);

  // next state, step index, idle timer and credit balance
  always_comb begin
    fsm_n      = fsm;
    estado_n   = estado;
    tcnt_n     = tcnt;
    creditos_n = creditos;
    fin_n      = 1'b0;
    hecho      = 1'b0;
    unique case (fsm)
      IDLE: begin
        estado_n = '0;
        tcnt_n   = '0;
        if (creditos != '0)
          fsm_n = ARMED;
      end
      ARMED: begin
        estado_n = '0;
        tcnt_n   = '0;
        if (creditos == '0)
          fsm_n = IDLE;
        else if (bp)
          fsm_n = RUN;
      end
      RUN: begin
        if (bp || tmo) begin
          if (estado >= ULT) begin
            hecho = 1'b1;
          end else begin
            estado_n = estado + 3'd1;
            tcnt_n   = '0;
          end
        end else if (tcnt != '1) begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      default: begin
        fsm_n    = IDLE;
        estado_n = '0;
        tcnt_n   = '0;
      end
    endcase

    // a coin and a completion in the same cycle cancel out
    if (mp && !hecho) begin
      if (creditos < CMAX)
        creditos_n = creditos + 4'd1;
    end else if (hecho && !mp) begin
      if (creditos != '0)
        creditos_n = creditos - 4'd1;
    end

    if (hecho) begin
      fin_n    = 1'b1;
      estado_n = '0;
      tcnt_n   = '0;
      fsm_n    = (creditos_n != '0) ? ARMED : IDLE;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= IDLE;
      estado   <= '0;
      avance   <= 1'b0;
      credito  <= 1'b0;
      creditos <= '0;
      fin      <= 1'b0;
      tcnt     <= '0;
    end else begin
      fsm      <= fsm_n;
      estado   <= estado_n;
      avance   <= (fsm_n == RUN);
      credito  <= (creditos_n != '0);
      creditos <= creditos_n;
      fin      <= fin_n;
      tcnt     <= tcnt_n;
    end
  end

endmodule

// File: tb/tb_secuenciador_estado.sv
// tb_secuenciador_estado: directed scenarios plus random
// stimulus against a cycle-level reference model.
module tb_secuenciador_estado;

  localparam int N    = 6;
  localparam int CMAX = 15;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic moneda = 1'b0;
  logic boton = 1'b0;

  logic [2:0] e8, e0;
  logic       a8, a0;
  logic       c8, c0;
  logic [3:0] cs8, cs0;
  logic       f8, f0;

  int ncmp = 0;
  int nerr = 0;

  int md [2];
  int est[2];
  int cr [2];
  int tc [2];
  bit fn [2];
  bit mh [3];
  bit bh [3];
  bit listo = 1'b0;

  always #5 clk = ~clk;

  secuenciador_estado #(
    .NUM_ESTADOS(N), .CREDITO_MAX(CMAX),
    .TIMEOUT_CYC(8)
  ) u8 (
    .clk(clk), .rst(rst),
    .moneda(moneda), .boton(boton),
    .estado(e8), .avance(a8),
    .credito(c8), .creditos(cs8), .fin(f8)
  );

  secuenciador_estado #(
    .NUM_ESTADOS(N), .CREDITO_MAX(CMAX),
    .TIMEOUT_CYC(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .moneda(moneda), .boton(boton),
    .estado(e0), .avance(a0),
    .credito(c0), .creditos(cs0), .fin(f0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d @%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference: one call per rising edge. A level seen at
  // edge E takes effect at E+2 if it was low at E-1.
  task automatic modelo();
    bit mp, bp, done, adv;
    int ncr, tmo;
    mp = mh[1] && !mh[2];
    bp = bh[1] && !bh[2];
    for (int k = 0; k < 2; k++) begin
      tmo = (k == 0) ? 8 : 0;
      if (rst) begin
        md[k] = M_IDLE; est[k] = 0;
        cr[k] = 0; tc[k] = 0; fn[k] = 0;
      end else begin
        fn[k] = 0;
        done = 0;
        if (md[k] == M_IDLE) begin
          if (cr[k] > 0) md[k] = M_ARMED;
        end else if (md[k] == M_ARMED) begin
          if (cr[k] == 0) md[k] = M_IDLE;
          else if (bp) begin
            md[k] = M_RUN; est[k] = 0; tc[k] = 0;
          end
        end else begin
          adv = bp || (tmo > 0 && tc[k] == tmo - 1);
          if (adv && est[k] == N - 1) done = 1;
          else if (adv) begin
            est[k]++; tc[k] = 0;
          end else if (tc[k] < (1 << 20)) tc[k]++;
        end
        ncr = cr[k];
        if (mp && !done) ncr = (cr[k] < CMAX) ? cr[k] + 1 : CMAX;
        if (done && !mp) ncr = cr[k] - 1;
        if (done) begin
          fn[k] = 1; est[k] = 0; tc[k] = 0;
          md[k] = (ncr > 0) ? M_ARMED : M_IDLE;
        end
        cr[k] = ncr;
      end
    end
    if (rst) begin
      mh = '{default: 0};
      bh = '{default: 0};
      listo = 1'b1;
    end else begin
      mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = moneda;
      bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = boton;
    end
  endtask

  // every cycle: advance the model, then compare both DUTs
  always begin
    @(posedge clk);
    modelo();
    #1;
    if (listo) begin
      chk("u8.estado", e8, est[0]);
      chk("u8.avance", a8, md[0] == M_RUN);
      chk("u8.credito", c8, cr[0] != 0);
      chk("u8.creditos", cs8, cr[0]);
      chk("u8.fin", f8, fn[0]);
      chk("u0.estado", e0, est[1]);
      chk("u0.avance", a0, md[1] == M_RUN);
      chk("u0.credito", c0, cr[1] != 0);
      chk("u0.creditos", cs0, cr[1]);
      chk("u0.fin", f0, fn[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; moneda = 1'b0; boton = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // returns at the first negedge where the effect is visible
  task automatic press_m();
    moneda = 1'b1; tick(1);
    moneda = 1'b0; tick(2);
  endtask

  task automatic press_b();
    boton = 1'b1; tick(1);
    boton = 1'b0; tick(2);
  endtask

  int at;

  initial begin
    tick(1);
    do_reset();
    chk("rst.estado", e8, 0);
    chk("rst.creditos", cs8, 0);

    // reset in the middle of a sequence
    press_m(); press_m(); tick(2);
    press_b();
    repeat (3) press_b();
    chk("mid.estado", e8, 3);
    chk("mid.creditos", cs8, 2);
    chk("mid.avance", a8, 1);
    rst = 1'b1; tick(2); rst = 1'b0;
    chk("rst2.estado", e8, 0);
    chk("rst2.avance", a8, 0);
    chk("rst2.credito", c8, 0);
    chk("rst2.creditos", cs8, 0);
    chk("rst2.fin", f8, 0);
    tick(1);
    chk("rst3.avance", a0, 0);

    // one coin, entry press, six advances
    press_m();
    chk("coin.credito", c8, 1);
    chk("coin.creditos", cs8, 1);
    tick(2);
    boton = 1'b1; tick(1); boton = 1'b0;
    chk("ent.av0", a8, 0);
    tick(1);
    chk("ent.av1", a8, 0);
    tick(1);
    chk("ent.av2", a8, 1);
    chk("ent.estado", e8, 0);
    for (int i = 1; i < N; i++) begin
      press_b();
      chk("step.estado", e0, i);
    end
    press_b();
    chk("end.fin", f0, 1);
    chk("end.creditos", cs0, 0);
    chk("end.avance", a0, 0);
    tick(1);
    chk("end.fin_off", f0, 0);

    // coin saturation and completion afterwards
    repeat (17) press_m();
    chk("sat.creditos", cs8, 15);
    chk("sat.creditos0", cs0, 15);
    tick(2);
    repeat (N + 1) press_b();
    chk("sat.fin", f8, 1);
    chk("sat.dec", cs8, 14);
    tick(2);
    press_b();
    chk("sat.armed", a8, 1);

    // auto-advance with an 8-cycle timeout
    do_reset();
    press_m(); tick(2);
    press_b();
    chk("to.run", a8, 1);
    at = 0;
    for (int i = 1; i <= 60 && at == 0; i++) begin
      tick(1);
      if (f8) at = i;
      if (i == 8) chk("to.step1", e8, 1);
    end
    chk("to.fin_at", at, 48);
    chk("to.u0_hold", e0, 0);

    // coin and final press in the same cycle
    do_reset();
    press_m(); tick(2);
    press_b();
    repeat (N - 1) press_b();
    chk("mix.estado", e0, N - 1);
    moneda = 1'b1; boton = 1'b1; tick(1);
    moneda = 1'b0; boton = 1'b0; tick(2);
    chk("mix.fin8", f8, 1);
    chk("mix.fin0", f0, 1);
    chk("mix.cr8", cs8, 1);
    chk("mix.cr0", cs0, 1);
    tick(2);
    press_b();
    chk("mix.armed", a0, 1);

    // held button gives one step only
    do_reset();
    press_m(); tick(2);
    boton = 1'b1;
    tick(50);
    chk("held.avance", a0, 1);
    chk("held.estado", e0, 0);
    boton = 1'b0;
    tick(3);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom_range(0, 399) == 0);
      moneda = ($urandom_range(0, 7) == 0);
      boton  = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    rst = 1'b0; moneda = 1'b0; boton = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
